sram_pin_emu: RTL

Synthesizable responder for the asynchronous-SRAM pin interface driven by the SRAM controller. It samples CS/WR/OE/ADDR/DATA pins on CLK, stores writes into an internal array and returns read data with a programmable wait-state latency. Used as an on-chip stand-in for one external 32-bit SRAM bank, one instance per bank, so the edge-mask lookup path and the init stream can run without board memory.

---
 rtl/sram_pin_emu.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_pin_emu.sv
// sram_pin_emu: on-chip stand-in for one external asynchronous 32-bit SRAM
// bank. The controller's CS/WR/OE/ADDR/DATA pins are registered once, and a
// small FSM acting on the registered copies stores writes into an internal
// array. Read data is returned after a programmable number of wait states.
//
// Optional feature macro: SRAM_EMU_ADDR_CHECK_EN
//   defined   - accesses with any address bit above MEMW set are rejected:
//               writes are dropped, reads return 32'hDEAD_BEEF, and err_cnt
//               counts them (saturating at 255).
//   undefined - upper address bits are ignored (aliasing), err_cnt is 0.

module sram_pin_emu #(
    parameter int ADDRW    = 19,
    parameter int DATAW    = 32,
    parameter int MEMW     = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SRAM_CS_Pin,
    input  logic             SRAM_WR_Pin,
    input  logic             SRAM_OE_Pin,
    input  logic [ADDRW-1:0] SRAM_ADDR_Pin,
    input  logic [DATAW-1:0] SRAM_DATA_IN_Pin,
    output logic [DATAW-1:0] SRAM_DATA_OUT_Pin,
    output logic             SRAM_DATA_OE,
    output logic             busy,
    output logic [7:0]       err_cnt
);

    localparam logic [3:0]       WAIT_LD  = 4'(WAIT_CYC);
    localparam int               DEPTH    = 1 << MEMW;
    localparam logic [DATAW-1:0] OOR_WORD = DATAW'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_DRIVE = 2'd2,
        ST_WR_HOLD  = 2'd3
    } state_t;

    // Registered pin copies (stage S); the FSM only ever looks at these.
    logic             cs_q;
    logic             wr_q;
    logic             oe_q;
    logic [ADDRW-1:0] addr_q;
    logic [DATAW-1:0] wdata_q;

    state_t           state_q,   state_d;
    logic [3:0]       cnt_q,     cnt_d;
    logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
    logic [MEMW-1:0]  wr_idx_q,  wr_idx_d;
    logic [DATAW-1:0] wr_data_q, wr_data_d;
    logic             wr_oor_q,  wr_oor_d;

    logic [DATAW-1:0] dout_q;
    logic             drive_q;

    logic             rd_fire_s;
    logic             wr_commit_s;
    logic             capture_s;
    logic             rd_oor_s;
    logic             cap_oor_s;

    logic [DATAW-1:0] mem [DEPTH];

`ifdef SRAM_EMU_ADDR_CHECK_EN
    logic [7:0] err_q;

    function automatic logic addr_oor(input logic [ADDRW-1:0] a);
        logic [ADDRW-1:0] hi;
        hi       = a >> MEMW;
        addr_oor = (hi != {ADDRW{1'b0}});
    endfunction

    assign rd_oor_s  = addr_oor(rd_addr_q);
    assign cap_oor_s = addr_oor(addr_q);
`else
    assign rd_oor_s  = 1'b0;
    assign cap_oor_s = 1'b0;
`endif

    // Input stage: register every pin once; idle (deasserted) after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            oe_q    <= 1'b1;
            addr_q  <= {ADDRW{1'b0}};
            wdata_q <= {DATAW{1'b0}};
        end else begin
            cs_q    <= SRAM_CS_Pin;
            wr_q    <= SRAM_WR_Pin;
            oe_q    <= SRAM_OE_Pin;
            addr_q  <= SRAM_ADDR_Pin;
            wdata_q <= SRAM_DATA_IN_Pin;
        end
    end

    // FSM next state, wait counter, read address latch and write capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        wr_oor_d    = wr_oor_q;
        rd_fire_s   = 1'b0;
        wr_commit_s = 1'b0;
        capture_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A write request wins over a simultaneous read request.
                if (!cs_q && !wr_q) begin
                    state_d   = ST_WR_HOLD;
                    capture_s = 1'b1;
                end else if (!cs_q && !oe_q) begin
                    state_d   = ST_RD_WAIT;
                    rd_addr_d = addr_q;
                    cnt_d     = WAIT_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // An abandoned read (CS/OE released) never reaches the bus.
                if (cs_q) begin
                    state_d = ST_IDLE;
                end else if (!wr_q) begin
                    state_d   = ST_WR_HOLD;
                    capture_s = 1'b1;
                end else if (oe_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d   = ST_RD_DRIVE;
                    rd_fire_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RD_DRIVE: begin
                if (cs_q) begin
                    state_d = ST_IDLE;
                end else if (!wr_q) begin
                    state_d   = ST_WR_HOLD;
                    capture_s = 1'b1;
                end else if (oe_q) begin
                    state_d = ST_IDLE;
                end else if (addr_q != rd_addr_q) begin
                    // New address under a held CS/OE starts a fresh access.
                    state_d   = ST_RD_WAIT;
                    rd_addr_d = addr_q;
                    cnt_d     = WAIT_LD;
                end else begin
                    state_d = ST_RD_DRIVE;
                end
            end
            ST_WR_HOLD: begin
                // Either WR rising or CS rising ends the write cycle.
                if (cs_q || wr_q) begin
                    state_d     = ST_IDLE;
                    wr_commit_s = 1'b1;
                end else begin
                    capture_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture_s) begin
            wr_idx_d  = addr_q[MEMW-1:0];
            wr_data_d = wdata_q;
            wr_oor_d  = cap_oor_s;
        end else begin
            wr_idx_d  = wr_idx_q;
            wr_data_d = wr_data_q;
            wr_oor_d  = wr_oor_q;
        end
    end

    // FSM state, counter and access bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            rd_addr_q <= {ADDRW{1'b0}};
            wr_idx_q  <= {MEMW{1'b0}};
            wr_data_q <= {DATAW{1'b0}};
            wr_oor_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            wr_oor_q  <= wr_oor_d;
        end
    end

    // Storage array: never reset; a write in flight during reset is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && wr_commit_s && !wr_oor_q) begin
            mem[wr_idx_q] <= wr_data_q;
        end
    end

    // Registered read data and bus-drive enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q  <= {DATAW{1'b0}};
            drive_q <= 1'b0;
        end else begin
            drive_q <= (state_d == ST_RD_DRIVE);
            if (rd_fire_s) begin
                dout_q <= rd_oor_s ? OOR_WORD : mem[rd_addr_q[MEMW-1:0]];
            end
        end
    end

`ifdef SRAM_EMU_ADDR_CHECK_EN
    // Saturating count of rejected accesses, one per access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 8'd0;
        end else if ((rd_fire_s && rd_oor_s) || (wr_commit_s && wr_oor_q)) begin
            if (err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign SRAM_DATA_OUT_Pin = dout_q;
    assign SRAM_DATA_OE      = drive_q;
    assign busy              = (state_q != ST_IDLE);

endmodule
